// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared width codes, arbiter state encoding and the
//                access-size helper for the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Width/sign codes carried on the ctrl buses
    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    // Arbiter states: one grant walks IDLE -> ACCESS -> RESP -> IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Bytes touched by a width code; illegal codes are caught by the checker
    function automatic logic [2:0] access_size(input logic [2:0] ctrl);
        case (ctrl[1:0])
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_req_check.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_req_check
//  Description : Combinational legality check of one memory request:
//                illegal width code, store with an unsigned code,
//                misalignment, or any byte beyond the end of memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_req_check
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 1024
)(
    input  logic [2:0]  i_ctrl,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    output logic        o_err
);

    logic [32:0] w_last;
    logic        w_bad_code;
    logic        w_bad_store;
    logic        w_misalign;
    logic        w_range;

    // Flag every reason a request must not reach memory
    always_comb begin
        // 33-bit sum so an address near 2^32 cannot wrap into range
        w_last      = {1'b0, i_addr} + 33'(access_size(i_ctrl)) - 33'd1;
        w_bad_code  = (i_ctrl == 3'b011) || (i_ctrl == 3'b110) || (i_ctrl == 3'b111);
        w_bad_store = i_we && ((i_ctrl == CTRL_BU) || (i_ctrl == CTRL_HU));
        w_misalign  = (((i_ctrl == CTRL_H) || (i_ctrl == CTRL_HU)) && i_addr[0])
                   || ((i_ctrl == CTRL_W) && (i_addr[1:0] != 2'b00));
        w_range     = (w_last >= 33'(MEM_BYTES));
        o_err       = w_bad_code || w_bad_store || w_misalign || w_range;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin arbiter sharing a single-port byte-addressed
//                data memory between the load/store unit (m0) and the
//                DMA/loader (m1). One access per grant; illegal requests are
//                answered with err and never touch memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES  = 1024,
    parameter bit PRIO_RESET = 1'b0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_ctrl,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_ctrl,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        mem_write,
    output logic [2:0]  mem_ctrl,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_prio;
    logic        r_owner;
    logic        r_we;
    logic        r_err;
    logic [2:0]  r_ctrl;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_grant;
    logic        w_sel;
    logic        w_sel_we;
    logic [2:0]  w_sel_ctrl;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_check_err;
    logic [31:0] w_load;

    // Choose the candidate: a lone request wins, a tie goes to the pointer
    always_comb begin
        w_sel       = (m0_req && m1_req) ? r_prio : m1_req;
        w_sel_we    = w_sel ? m1_we    : m0_we;
        w_sel_ctrl  = w_sel ? m1_ctrl  : m0_ctrl;
        w_sel_addr  = w_sel ? m1_addr  : m0_addr;
        w_sel_wdata = w_sel ? m1_wdata : m0_wdata;
    end

    dmem_req_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_req_check (
        .i_ctrl (w_sel_ctrl),
        .i_we   (w_sel_we),
        .i_addr (w_sel_addr),
        .o_err  (w_check_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the strobes that are only live in ACCESS/RESP
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        mem_write    = 1'b0;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        m0_err       = 1'b0;
        m1_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    w_grant      = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                // rst gating keeps a reset in this cycle from committing a store
                mem_write    = r_we && !r_err && !rst;
                w_state_next = RESP;
            end
            RESP: begin
                m0_ack       = !r_owner && !rst;
                m1_ack       =  r_owner && !rst;
                m0_err       = !r_owner && r_err && !rst;
                m1_err       =  r_owner && r_err && !rst;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Latch the granted request; the pointer moves to the non-owner in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio  <= PRIO_RESET;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_ctrl  <= CTRL_W;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_sel;
                r_we    <= w_sel_we;
                r_err   <= w_check_err;
                r_ctrl  <= w_sel_ctrl;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (r_state == RESP) begin
                r_prio <= !r_owner;
            end
        end
    end

    // Stores and rejected requests return zero instead of the memory data
    assign w_load = (r_we || r_err) ? 32'd0 : mem_read_data;

    // Capture the load result for the owner at the end of ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if (r_state == ACCESS) begin
            if (r_owner) begin
                r_m1_rdata <= w_load;
            end else begin
                r_m0_rdata <= w_load;
            end
        end
    end

    // Memory-side fields only change on a grant, so they hold outside ACCESS.
    // The ctrl latch resets to the word code, which is the idle memory code.
    assign mem_ctrl       = r_ctrl;
    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign m0_rdata       = r_m0_rdata;
    assign m1_rdata       = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter: byte memory model,
//                vector table on both requesters, scoreboard of expected
//                responses, plus contention / reset / held-field sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [2:0]  m0_ctrl, m1_ctrl;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_write;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    logic [7:0]  mem [MEM_BYTES];
    logic        mem_clr;
    logic [9:0]  a0, a1, a2, a3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_total = 0;
    int both_cnt = 0;
    int ack_own[$];
    int ack_cyc[$];

    typedef struct {
        logic        m;
        logic        err;
        logic [31:0] rdata;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        m;
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MEM_BYTES  (MEM_BYTES),
        .PRIO_RESET (1'b0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_ctrl        (m0_ctrl),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_ack         (m0_ack),
        .m0_err         (m0_err),
        .m0_rdata       (m0_rdata),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_ctrl        (m1_ctrl),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_ack         (m1_ack),
        .m1_err         (m1_err),
        .m1_rdata       (m1_rdata),
        .mem_write      (mem_write),
        .mem_ctrl       (mem_ctrl),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Little-endian byte memory with combinational, sign-aware reads
    assign a0 = 10'(mem_address & 32'(MEM_BYTES - 1));
    assign a1 = a0 + 10'd1;
    assign a2 = a0 + 10'd2;
    assign a3 = a0 + 10'd3;

    always_comb begin
        mem_read_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
        case (mem_ctrl)
            CTRL_B:  mem_read_data = {{24{mem[a0][7]}}, mem[a0]};
            CTRL_BU: mem_read_data = {24'h0, mem[a0]};
            CTRL_H:  mem_read_data = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            CTRL_HU: mem_read_data = {16'h0, mem[a1], mem[a0]};
            default: ;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_clr) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else if (mem_write) begin
            mem[a0] <= mem_write_data[7:0];
            if (mem_ctrl[1:0] != 2'b00) mem[a1] <= mem_write_data[15:8];
            if (mem_ctrl[1:0] == 2'b10) begin
                mem[a2] <= mem_write_data[23:16];
                mem[a3] <= mem_write_data[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_ack(input logic m, input logic err, input logic [31:0] rdata);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack: m%0d acked with nothing outstanding at cycle %0d", m, cyc);
        end else begin
            e = sb.pop_front();
            if (e.m !== m || e.err !== err || e.rdata !== rdata) begin
                failures++;
                $display("FAIL scoreboard: got m%0d err=%0b rdata=0x%08h expected m%0d err=%0b rdata=0x%08h",
                         m, err, rdata, e.m, e.err, e.rdata);
            end
        end
    endtask

    // Response monitor: every ack is matched against the scoreboard
    always @(negedge clk) begin
        if (mem_write) wr_total++;
        if (m0_ack && m1_ack) both_cnt++;
        if (m0_ack) begin
            ack_own.push_back(0);
            ack_cyc.push_back(cyc);
            check_ack(1'b0, m0_err, m0_rdata);
        end
        if (m1_ack) begin
            ack_own.push_back(1);
            ack_cyc.push_back(cyc);
            check_ack(1'b1, m1_err, m1_rdata);
        end
    end

    task automatic expect_resp(input logic m, input logic err, input logic [31:0] rdata);
        sb_t e;
        e.m = m; e.err = err; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic drive(input logic m, input logic we, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_ctrl = ctrl; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_ctrl = ctrl; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic add_vec(input logic m, input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
        vec_t v;
        v.m = m; v.we = we; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
        vecs.push_back(v);
    endtask

    // One complete transaction on an otherwise idle arbiter
    task automatic do_req(input logic m, input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic err, input logic [31:0] rdata, input string name);
        int w0;
        int waited;
        bit got;
        @(posedge clk); #1;
        expect_resp(m, err, rdata);
        w0 = wr_total;
        drive(m, we, ctrl, addr, wdata);
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 10) begin
            @(negedge clk);
            waited++;
            got = m ? m1_ack : m0_ack;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no ack after %0d cycles, required ack", name, waited);
            sb.delete();
        end else begin
            chk({name, "_latency"}, 32'(waited), 32'd3);
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk({name, "_writes"}, 32'(wr_total - w0), (we && !err) ? 32'd1 : 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int w0;
        int n0;
        int waited;
        vec_t v;

        rst = 1'b1; mem_clr = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_ctrl = 3'b000; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_ctrl = 3'b000; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; mem_clr = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_m0_ack",   32'(m0_ack),    32'd0);
        chk("rst_m1_ack",   32'(m1_ack),    32'd0);
        chk("rst_errs",     32'({m0_err, m1_err}), 32'd0);
        chk("rst_m0_rdata", m0_rdata,       32'd0);
        chk("rst_m1_rdata", m1_rdata,       32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_ctrl", 32'(mem_ctrl),  32'h2);
        chk("rst_mem_addr", mem_address,    32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);

        // m, we, ctrl, addr, wdata, err, rdata
        add_vec(0, 1, CTRL_W,  32'h10,       32'hDEADBEEF, 0, 32'h0);
        add_vec(0, 0, CTRL_W,  32'h10,       32'h0,        0, 32'hDEADBEEF);
        add_vec(0, 1, CTRL_B,  32'h5,        32'h00000080, 0, 32'h0);
        add_vec(0, 0, CTRL_B,  32'h5,        32'h0,        0, 32'hFFFFFF80);
        add_vec(0, 0, CTRL_BU, 32'h5,        32'h0,        0, 32'h00000080);
        add_vec(0, 0, CTRL_W,  32'h2,        32'h0,        1, 32'h0);
        add_vec(0, 1, CTRL_H,  32'h3,        32'h1234,     1, 32'h0);
        add_vec(0, 0, CTRL_W,  32'd1022,     32'h0,        1, 32'h0);
        add_vec(0, 0, 3'b111,  32'h0,        32'h0,        1, 32'h0);
        add_vec(0, 1, CTRL_HU, 32'h0,        32'h5555,     1, 32'h0);
        add_vec(0, 0, 3'b011,  32'h0,        32'h0,        1, 32'h0);
        add_vec(1, 1, CTRL_H,  32'h3FE,      32'h0000A5B6, 0, 32'h0);
        add_vec(1, 0, CTRL_HU, 32'h3FE,      32'h0,        0, 32'h0000A5B6);
        add_vec(1, 0, CTRL_H,  32'h3FE,      32'h0,        0, 32'hFFFFA5B6);
        add_vec(1, 0, CTRL_W,  32'hFFFFFFFC, 32'h0,        1, 32'h0);
        add_vec(1, 0, CTRL_B,  32'h400,      32'h0,        1, 32'h0);
        add_vec(1, 1, CTRL_BU, 32'h0,        32'h1,        1, 32'h0);
        add_vec(1, 1, CTRL_W,  32'h3FC,      32'h11223344, 0, 32'h0);
        add_vec(1, 0, CTRL_BU, 32'h3FF,      32'h0,        0, 32'h00000011);
        add_vec(0, 0, CTRL_W,  32'h10,       32'h0,        0, 32'hDEADBEEF);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            do_req(v.m, v.we, v.ctrl, v.addr, v.wdata, v.err, v.rdata, $sformatf("vec%0d", i));
        end
        // m1's last load result survives an intervening m0 transaction
        chk("m1_rdata_hold", m1_rdata, 32'h00000011);

        // Contention: both requesters hold req from right after reset
        do_reset();
        ack_own.delete();
        ack_cyc.delete();
        both_cnt = 0;
        expect_resp(0, 0, 32'hDEADBEEF);
        expect_resp(1, 0, 32'h000000EF);
        expect_resp(0, 0, 32'hDEADBEEF);
        expect_resp(1, 0, 32'h000000EF);
        drive(0, 0, CTRL_W,  32'h10, 32'h0);
        drive(1, 0, CTRL_BU, 32'h10, 32'h0);
        waited = 0;
        while (ack_own.size() < 4 && waited < 30) begin
            @(negedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("cont_ack_count", 32'(ack_own.size()), 32'd4);
        if (ack_own.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cont_owner%0d", i), 32'(ack_own[i]), 32'(i % 2));
            end
            for (int i = 1; i < 4; i++) begin
                chk($sformatf("cont_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
            end
        end
        chk("cont_no_overlap", 32'(both_cnt), 32'd0);
        repeat (2) @(posedge clk);
        sb.delete();

        // Reset during the ACCESS cycle of a store: no write, no ack
        @(posedge clk); #1;
        w0 = wr_total;
        n0 = ack_own.size();
        drive(0, 1, CTRL_W, 32'h20, 32'hCAFEF00D);
        @(posedge clk); #1;
        rst    = 1'b1;
        m0_req = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_no_ack",  32'(ack_own.size() - n0), 32'd0);
        chk("rstmid_no_write", 32'(wr_total - w0), 32'd0);
        chk("rstmid_mem20", {mem[35], mem[34], mem[33], mem[32]}, 32'd0);
        do_req(0, 0, CTRL_W, 32'h20, 32'h0,        0, 32'h0,        "after_rst_load");
        do_req(0, 1, CTRL_W, 32'h20, 32'hCAFEF00D, 0, 32'h0,        "after_rst_store");
        do_req(0, 0, CTRL_W, 32'h20, 32'h0,        0, 32'hCAFEF00D, "after_rst_reload");

        // m1 alters its fields after the grant; the latched copy must be used
        @(posedge clk); #1;
        expect_resp(1, 0, 32'h0);
        drive(1, 1, CTRL_B, 32'h30, 32'h00000011);
        @(posedge clk); #1;
        m1_wdata = 32'h00000022;
        @(posedge clk); #1;
        m1_wdata = 32'h00000033;
        @(negedge clk);
        chk("held_ack", 32'(m1_ack), 32'd1);
        @(posedge clk); #1;
        m1_req = 1'b0;
        chk("held_mem30", 32'(mem[48]), 32'h11);
        do_req(1, 0, CTRL_BU, 32'h30, 32'h0, 0, 32'h00000011, "held_reload");

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on run time
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
